// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, debounce FSM states and the
// one-hot key vector helpers used by both the debouncer and the entry logic.
package keypad_pkg;

   localparam logic [3:0] KEY_STAR = 4'hA;
   localparam logic [3:0] KEY_HASH = 4'hB;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_PRESSED,
      ST_RELEASE
   } db_state_e;

   function automatic logic is_one_hot(input logic [11:0] v);
      return (v != 12'h000) && ((v & (v - 12'h001)) == 12'h000);
   endfunction

   // Bits 0..8 are '1'..'9', bit 9 '*', bit 10 '0', bit 11 '#'.
   function automatic logic [3:0] key_decode(input logic [11:0] onehot);
      logic [3:0] code;
      code = 4'h0;
      for (int i = 0; i < 9; i++) begin
         if (onehot[i]) code = 4'(i + 1);
      end
      if (onehot[9])  code = KEY_STAR;
      if (onehot[10]) code = 4'h0;
      if (onehot[11]) code = KEY_HASH;
      return code;
   endfunction

endpackage

// File: rtl/key_entry_if.sv
// Keypad entry bus: scanner key vector in, accepted key and entry state out.
interface key_entry_if;
   logic [11:0] key_data;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [15:0] entry_value;
   logic [2:0]  digit_count;
   logic        entry_done;

   modport master (
      output key_data,
      input  key_valid, key_code, entry_value, digit_count, entry_done
   );

   modport slave (
      input  key_data,
      output key_valid, key_code, entry_value, digit_count, entry_done
   );
endinterface

// File: rtl/key_debounce.sv
// Debounce FSM for the one-hot key vector; accept_o is a combinational
// pulse on the DEBOUNCE->PRESSED transition, sample_o the captured key.
module key_debounce
   import keypad_pkg::*;
#(
   parameter int DB_CNT = 160000,
   parameter int CNT_W  = 18
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] key_data_i,
   output logic        accept_o,
   output logic [11:0] sample_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [11:0]      sample_q, sample_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sample_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sample_q <= sample_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sample_d = sample_q;
      accept_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (is_one_hot(key_data_i)) begin
               sample_d = key_data_i;
               cnt_d    = '0;
               state_d  = ST_DEBOUNCE;
            end
         end
         ST_DEBOUNCE: begin
            if (key_data_i != sample_q) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = ST_PRESSED;
               accept_o = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_PRESSED: begin
            // Held keys stay here; only a full release re-arms the FSM.
            if (key_data_i == 12'h000) begin
               cnt_d   = '0;
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (key_data_i != 12'h000) begin
               state_d = ST_PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign sample_o = sample_q;

endmodule

// File: rtl/key_entry.sv
// Keypad entry top: debounces keys, decodes them and maintains a
// four-digit packed-BCD entry committed with '#' and cleared with '*'.
module key_entry
   import keypad_pkg::*;
#(
   parameter int DB_CNT = 160000,
   parameter int CNT_W  = 18
) (
   input  logic      clk,
   input  logic      rst,
   key_entry_if.slave bus
);

   logic        accept;
   logic [11:0] sample;
   logic [3:0]  code;

   logic        key_valid_q, key_valid_d;
   logic [3:0]  key_code_q, key_code_d;
   logic [15:0] entry_value_q, entry_value_d;
   logic [2:0]  digit_count_q, digit_count_d;
   logic        entry_done_q, entry_done_d;

   key_debounce #(
      .DB_CNT (DB_CNT),
      .CNT_W  (CNT_W)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .key_data_i (bus.key_data),
      .accept_o   (accept),
      .sample_o   (sample)
   );

   assign code = key_decode(sample);

   always_comb begin
      key_valid_d   = accept;
      key_code_d    = key_code_q;
      entry_value_d = entry_value_q;
      digit_count_d = digit_count_q;
      entry_done_d  = 1'b0;
      if (accept) begin
         key_code_d = code;
         if (code <= 4'h9) begin
            // A fifth digit is dropped; the press itself is still reported.
            if (digit_count_q == 3'd0) begin
               entry_value_d = {12'h000, code};
               digit_count_d = 3'd1;
            end else if (digit_count_q < 3'd4) begin
               entry_value_d = {entry_value_q[11:0], code};
               digit_count_d = digit_count_q + 3'd1;
            end
         end else if (code == KEY_STAR) begin
            entry_value_d = 16'h0000;
            digit_count_d = 3'd0;
         end else if (code == KEY_HASH) begin
            if (digit_count_q != 3'd0) begin
               entry_done_d  = 1'b1;
               digit_count_d = 3'd0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_valid_q   <= 1'b0;
         key_code_q    <= 4'h0;
         entry_value_q <= 16'h0000;
         digit_count_q <= 3'd0;
         entry_done_q  <= 1'b0;
      end else begin
         key_valid_q   <= key_valid_d;
         key_code_q    <= key_code_d;
         entry_value_q <= entry_value_d;
         digit_count_q <= digit_count_d;
         entry_done_q  <= entry_done_d;
      end
   end

   assign bus.key_valid   = key_valid_q;
   assign bus.key_code    = key_code_q;
   assign bus.entry_value = entry_value_q;
   assign bus.digit_count = digit_count_q;
   assign bus.entry_done  = entry_done_q;

endmodule

// File: tb/tb_key_entry.sv
// Scoreboard bench for key_entry with a short debounce length.
module tb_key_entry;

   localparam int DB = 4;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] val;
      logic [2:0]  cnt;
      logic        done;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   edge_cnt = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t sb_q[$];

   key_entry_if ifc ();

   key_entry #(
      .DB_CNT (DB),
      .CNT_W  (18)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, edge_cnt);
      end
   endtask

   // Pop one expectation per key_valid pulse; entry_done must never appear alone.
   always @(negedge clk) begin
      if (rst) begin
         if (ifc.key_valid) begin
            chk("valid_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               exp_t e;
               e = sb_q.pop_front();
               $display("[TB] key_valid cyc=%0d code=%h value=%h count=%0d done=%0b",
                        edge_cnt, ifc.key_code, ifc.entry_value, ifc.digit_count, ifc.entry_done);
               chk("key_code", 32'(ifc.key_code), 32'(e.code));
               chk("entry_value", 32'(ifc.entry_value), 32'(e.val));
               chk("digit_count", 32'(ifc.digit_count), 32'(e.cnt));
               chk("entry_done", 32'(ifc.entry_done), 32'(e.done));
               chk("latency", 32'(edge_cnt), 32'(e.cyc));
            end
         end else begin
            chk("done_alone", 32'(ifc.entry_done), 32'd0);
         end
      end
   end

   task automatic press(input logic [11:0] kd, input int hold, input logic [3:0] code,
                        input logic [15:0] val, input logic [2:0] cnt, input logic done);
      exp_t e;
      @(posedge clk);
      #1;
      ifc.key_data = kd;
      e.code = code;
      e.val  = val;
      e.cnt  = cnt;
      e.done = done;
      e.cyc  = edge_cnt + DB + 1;
      sb_q.push_back(e);
      repeat (hold) @(posedge clk);
      #1 ifc.key_data = 12'h000;
      repeat (12) @(posedge clk);
      chk("drain", 32'(sb_q.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      ifc.key_data = 12'h000;
      #12;
      chk("rst_key_valid", 32'(ifc.key_valid), 32'd0);
      chk("rst_key_code", 32'(ifc.key_code), 32'd0);
      chk("rst_entry_value", 32'(ifc.entry_value), 32'd0);
      chk("rst_digit_count", 32'(ifc.digit_count), 32'd0);
      chk("rst_entry_done", 32'(ifc.entry_done), 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);

      // First key, timed from first stable cycle.
      press(12'h001, 10, 4'h1, 16'h0001, 3'd1, 1'b0);

      // Bounce on '2' before it settles.
      @(posedge clk);
      #1 ifc.key_data = 12'h002;
      repeat (2) @(posedge clk);
      #1 ifc.key_data = 12'h000;
      @(posedge clk);
      press(12'h002, 10, 4'h2, 16'h0012, 3'd2, 1'b0);

      // Clear, then five digits: the fifth is dropped.
      press(12'h200, 8, 4'hA, 16'h0000, 3'd0, 1'b0);
      press(12'h001, 8, 4'h1, 16'h0001, 3'd1, 1'b0);
      press(12'h002, 8, 4'h2, 16'h0012, 3'd2, 1'b0);
      press(12'h004, 8, 4'h3, 16'h0123, 3'd3, 1'b0);
      press(12'h008, 8, 4'h4, 16'h1234, 3'd4, 1'b0);
      press(12'h010, 8, 4'h5, 16'h1234, 3'd4, 1'b0);
      press(12'h200, 8, 4'hA, 16'h0000, 3'd0, 1'b0);

      // '#' on an empty entry does not commit.
      press(12'h800, 8, 4'hB, 16'h0000, 3'd0, 1'b0);

      // 9, 0, '#' commits; next digit starts a fresh entry.
      press(12'h100, 8, 4'h9, 16'h0009, 3'd1, 1'b0);
      press(12'h400, 8, 4'h0, 16'h0090, 3'd2, 1'b0);
      press(12'h800, 8, 4'hB, 16'h0090, 3'd0, 1'b1);
      press(12'h040, 8, 4'h7, 16'h0007, 3'd1, 1'b0);

      // Multi-bit vector is ignored.
      @(posedge clk);
      #1 ifc.key_data = 12'h003;
      repeat (20) @(posedge clk);
      #1 ifc.key_data = 12'h000;
      repeat (12) @(posedge clk);
      chk("multibit_none", 32'(sb_q.size()), 32'd0);
      chk("multibit_count", 32'(ifc.digit_count), 32'd1);
      chk("hold_key_code", 32'(ifc.key_code), 32'h7);

      // Long hold of '0' gives exactly one press.
      press(12'h400, 100, 4'h0, 16'h0070, 3'd2, 1'b0);

      // Reset during DEBOUNCE; key held through reset release.
      @(posedge clk);
      #1 ifc.key_data = 12'h010;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_key_valid", 32'(ifc.key_valid), 32'd0);
      chk("arst_key_code", 32'(ifc.key_code), 32'd0);
      chk("arst_entry_value", 32'(ifc.entry_value), 32'd0);
      chk("arst_digit_count", 32'(ifc.digit_count), 32'd0);
      chk("arst_entry_done", 32'(ifc.entry_done), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      e.code = 4'h5;
      e.val  = 16'h0005;
      e.cnt  = 3'd1;
      e.done = 1'b0;
      e.cyc  = edge_cnt + DB + 1;
      sb_q.push_back(e);
      repeat (10) @(posedge clk);
      #1 ifc.key_data = 12'h000;
      repeat (12) @(posedge clk);
      chk("drain_after_reset", 32'(sb_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
